// File: rtl/scoreboard_hazard.sv
// Per-register pending-write scoreboard beside decode.
// Tracks long-latency writers until writeback and stalls hazards.
module scoreboard_hazard #(
   parameter int NUM_REGS        = 32,
   parameter int ADDR_W          = 5,
   parameter int CNT_W           = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter int OUT_W           = 3,
   parameter int WB_BYPASS       = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                issue_valid,
   output logic                issue_ready,
   input  logic [ADDR_W-1:0]   issue_rs_addr,
   input  logic [ADDR_W-1:0]   issue_rt_addr,
   input  logic                issue_reads_rs,
   input  logic                issue_reads_rt,
   input  logic                issue_we,
   input  logic [ADDR_W-1:0]   issue_dst_addr,
   input  logic                issue_long,
   input  logic                wb_valid,
   input  logic [ADDR_W-1:0]   wb_addr,
   input  logic                flush,
   output logic [NUM_REGS-1:0] busy_mask,
   output logic [OUT_W-1:0]    outstanding,
   output logic                sb_err,
   output logic [31:0]         stall_cycles
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

   logic [CNT_W-1:0]    cnt_q [NUM_REGS];
   logic [NUM_REGS-1:0] pend;
   logic                wb_hit;
   logic                wb_bad;
   logic                is_lw;
   logic                raw_stall;
   logic                waw_stall;
   logic                sat_stall;
   logic                lim_stall;
   logic                accept;

   // pend hides a register whose last pending write retires this cycle
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         busy_mask[i] = cnt_q[i] != '0;
         pend[i]      = busy_mask[i] && (i != 0);
         if (WB_BYPASS != 0 && wb_valid &&
             wb_addr == ADDR_W'(i) && cnt_q[i] == CNT_ONE)
            pend[i] = 1'b0;
      end
   end

   assign wb_hit = wb_valid && (cnt_q[wb_addr] != '0);
   assign wb_bad = wb_valid && (cnt_q[wb_addr] == '0);
   assign is_lw  = issue_we && issue_long;

   assign raw_stall = (issue_reads_rs && pend[issue_rs_addr]) ||
                      (issue_reads_rt && pend[issue_rt_addr]);
   assign waw_stall = issue_we && !issue_long && pend[issue_dst_addr];
   assign sat_stall = is_lw && (cnt_q[issue_dst_addr] == CNT_MAX);
   assign lim_stall = is_lw && (outstanding == OUT_MAX) && !wb_hit;

   assign issue_ready = !(raw_stall || waw_stall || sat_stall || lim_stall);
   assign accept      = issue_valid && issue_ready && is_lw &&
                        (issue_dst_addr != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
         outstanding <= '0;
      end else if (flush) begin
         for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
         outstanding <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (accept && issue_dst_addr == ADDR_W'(i) &&
                !(wb_hit && wb_addr == ADDR_W'(i)))
               cnt_q[i] <= cnt_q[i] + CNT_ONE;
            else if (wb_hit && wb_addr == ADDR_W'(i) &&
                     !(accept && issue_dst_addr == ADDR_W'(i)))
               cnt_q[i] <= cnt_q[i] - CNT_ONE;
         end
         if (accept && !wb_hit)
            outstanding <= outstanding + OUT_W'(1);
         else if (wb_hit && !accept)
            outstanding <= outstanding - OUT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_err       <= 1'b0;
         stall_cycles <= '0;
      end else begin
         if (wb_bad) sb_err <= 1'b1;
         if (issue_valid && !issue_ready && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
      end
   end

endmodule

// File: doc/scoreboard_hazard.md
Name: scoreboard_hazard

Overview:
- Parametrised hazard-tracking block that replaces single-stage load-use stall detection with a per-register pending-write scoreboard.
- Sits beside decode. Decode presents each instruction's source/destination usage; the block grants issue (issue_ready) or stalls.
- Long-latency writers (loads, mul, future multi-cycle units) are tracked until their writeback. Short ops are covered by forwarding and are not tracked.
- Supports multiple outstanding long writes, a global outstanding limit, flush, error flagging and stall statistics.

Parameters:
- NUM_REGS, 32: architectural registers; register 0 is hard-wired zero.
- ADDR_W, 5: register address width; must equal clog2(NUM_REGS).
- CNT_W, 2: width of each per-register pending counter. Max pending per register is 2^CNT_W-1.
- MAX_OUTSTANDING, 4: global limit on in-flight long writes.
- OUT_W, 3: width of the outstanding counter; must hold MAX_OUTSTANDING.
- WB_BYPASS, 1: 1 means a same-cycle writeback clears a RAW hazard combinationally.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  decode has an instruction to issue
- issue_ready  out  1  instruction may issue this cycle (combinational from state and inputs)
- issue_rs_addr  in  ADDR_W  source 1
- issue_rt_addr  in  ADDR_W  source 2
- issue_reads_rs  in  1  instruction reads rs
- issue_reads_rt  in  1  instruction reads rt
- issue_we  in  1  instruction writes a register
- issue_dst_addr  in  ADDR_W  destination register
- issue_long  in  1  destination write is long-latency (tracked)
- wb_valid  in  1  long-latency writeback completing this cycle
- wb_addr  in  ADDR_W  writeback destination
- flush  in  1  synchronous clear of all tracking (pipeline killed)
- busy_mask  out  NUM_REGS  bit i set when count[i]!=0
- outstanding  out  OUT_W  in-flight long writes
- sb_err  out  1  sticky: writeback to a register with count 0
- stall_cycles  out  32  saturating count of cycles with issue_valid & ~issue_ready

Behaviour:
- Reset (rst_n low, asynchronous): all counts 0, outstanding 0, sb_err 0, stall_cycles 0. Consequently busy_mask is 0 and issue_ready equals 1.
- Effective busy:
  - pend(r) = count[r]!=0 and r!=0.
  - If WB_BYPASS=1 and wb_valid and wb_addr==r and count[r]==1, then pend(r)=0 for the issue check.
- Stall conditions (issue_ready=0 if any is true):
  - RAW: issue_reads_rs & pend(rs), or issue_reads_rt & pend(rt).
  - WAW-short: issue_we & ~issue_long & pend(dst). A short write would otherwise complete before the older long write.
  - Counter saturation: issue_we & issue_long & count[dst]==2^CNT_W-1.
  - Global limit: issue_we & issue_long & outstanding==MAX_OUTSTANDING, with no same-cycle wb_valid freeing a slot.
- Ordering: long writes complete in order among themselves, so long-after-long to the same destination is allowed up to counter saturation.
- Accept condition: accept = issue_valid & issue_ready & issue_we & issue_long & dst!=0. A dst of 0 is never tracked.
- Clock edge updates:
  - On accept: count[dst]+1 and outstanding+1.
  - On wb_valid with count[wb_addr]!=0: count[wb_addr]-1 and outstanding-1.
  - Accept and writeback in the same cycle, same register: count unchanged. Different registers: both updates apply. outstanding is net unchanged in either case.
  - wb_valid with count[wb_addr]==0 (including wb_addr==0): no count change; sb_err set to 1 and held until reset.
- flush: all counts and outstanding cleared next edge. A same-cycle accept or writeback is ignored. sb_err and stall_cycles are kept.
- stall_cycles increments each cycle with issue_valid & ~issue_ready, holding at 0xFFFFFFFF.
- Latency: busy_mask and outstanding reflect an accept or writeback one cycle after the edge. issue_ready reacts in the same cycle to issue_* and wb_*.
- No hidden state beyond counts, outstanding, sb_err and stall_cycles.

Test Plan:
- Reset, then issue_valid with reads_rs=1, rs=5 → issue_ready=1, busy_mask=0, outstanding=0.
- Long write to r8, then next cycle read r8 → issue_ready=0 and stall_cycles increments. wb_valid wb_addr=8 in a later cycle → issue_ready=1 the same cycle (WB_BYPASS=1); busy_mask[8]=0 after the edge.
- Three back-to-back long writes to r3 (CNT_W=2) → count reaches 3. A fourth long write to r3 stalls. Short write to r3 stalls on WAW.
- Four long writes to r1..r4 → outstanding=4. A fifth long write to r6 stalls. Same cycle with wb_valid wb_addr=1 → the r6 write issues; outstanding stays 4.
- wb_valid wb_addr=9 with count[9]=0 → sb_err=1, counts unchanged. sb_err stays 1 across flush; clears only on rst_n low.
- Pending r2 and r7, assert flush together with an accept to r10 → next cycle busy_mask=0, outstanding=0. rst_n pulsed low mid-stream → all outputs return to reset values immediately, without a clock edge.
